// File: rtl/sprite_pkg.sv
// Shared constants for the sprite pixel read path.
// Colour format is RGB 3-3-3; all-ones marks a see-through texel.
package sprite_pkg;
   localparam int COLOR_WIDTH = 9;
   localparam logic [COLOR_WIDTH-1:0] TRANSPARENT = 9'h1FF;
   localparam logic [COLOR_WIDTH-1:0] BACKGROUND = 9'h000;
   localparam logic SYNC_IDLE = 1'b1;
endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth shift register with an async active-low reset.
// Every stage resets to RESET_VAL so the line comes out of reset idle.
module pipe_delay #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);
   logic [WIDTH-1:0] stage [DEPTH];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
      end else begin
         stage[0] <= din;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign dout = stage[DEPTH-1];
endmodule

// File: rtl/sprite_pixel_reader.sv
// Issues sprite ROM reads, keeps video timing aligned with the ROM data,
// resolves transparency and counts opaque sprite pixels per frame.
module sprite_pixel_reader #(
   parameter int ADDRESS_MEMORY = 10,
   parameter int QTD_MEMORY_ELEMENT = 4,
   parameter int ROM_LATENCY = 2,
   parameter int COLOR_WIDTH = sprite_pkg::COLOR_WIDTH
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic                                      enable,
   input  logic [ADDRESS_MEMORY-1:0]                 address,
   input  logic [QTD_MEMORY_ELEMENT-1:0]             element,
   input  logic                                      videoEnable,
   input  logic                                      hsync_in,
   input  logic                                      vsync_in,
   output logic [ADDRESS_MEMORY-1:0]                 rom_address,
   output logic [QTD_MEMORY_ELEMENT-1:0]             rom_read,
   input  logic [QTD_MEMORY_ELEMENT*COLOR_WIDTH-1:0] rom_data,
   output logic [COLOR_WIDTH-1:0]                    rgb,
   output logic                                      hsync_out,
   output logic                                      vsync_out,
   output logic                                      videoEnable_out,
   output logic [15:0]                               hit_count,
   output logic                                      element_error
);
   import sprite_pkg::*;

   localparam int IDX_W = (QTD_MEMORY_ELEMENT > 1) ? $clog2(QTD_MEMORY_ELEMENT) : 1;
   localparam int DLW = IDX_W + 4;
   localparam logic [DLW-1:0] DL_IDLE = {SYNC_IDLE, SYNC_IDLE, 2'b00, {IDX_W{1'b0}}};

   logic [QTD_MEMORY_ELEMENT-1:0] sel;
   logic [IDX_W-1:0]              sel_idx;
   logic                          found;
   logic                          multi;
   logic                          req_en;
   logic                          req_bad;

   always_comb begin
      sel = '0;
      sel_idx = '0;
      found = 1'b0;
      for (int i = 0; i < QTD_MEMORY_ELEMENT; i++) begin
         if (element[i] && !found) begin
            sel[i] = 1'b1;
            sel_idx = IDX_W'(i);
            found = 1'b1;
         end
      end
   end

   assign multi = (element & (element - 1'b1)) != '0;
   assign req_en = enable & found;
   assign req_bad = enable & (~found | multi);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rom_address <= '0;
         rom_read <= '0;
         element_error <= 1'b0;
      end else begin
         rom_address <= address;
         rom_read <= req_en ? sel : '0;
         if (req_bad) element_error <= 1'b1;
      end
   end

   // First stage of the line is the request register itself, so one extra
   // stage lines the request up with rom_data ROM_LATENCY cycles later.
   logic [DLW-1:0]   dl_in;
   logic [DLW-1:0]   dl_out;
   logic             d_vs;
   logic             d_hs;
   logic             d_ve;
   logic             d_en;
   logic [IDX_W-1:0] d_idx;

   assign dl_in = {vsync_in, hsync_in, videoEnable, req_en, sel_idx};

   pipe_delay #(
      .WIDTH(DLW),
      .DEPTH(ROM_LATENCY + 1),
      .RESET_VAL(DL_IDLE)
   ) u_delay (
      .clk(clk),
      .reset(reset),
      .din(dl_in),
      .dout(dl_out)
   );

   assign {d_vs, d_hs, d_ve, d_en, d_idx} = dl_out;

   logic [COLOR_WIDTH-1:0] d;
   logic                   hit;
   logic                   vs_fall;
   logic [15:0]            counter;

   assign d = rom_data[d_idx*COLOR_WIDTH +: COLOR_WIDTH];
   assign hit = d_ve & d_en & (d != COLOR_WIDTH'(TRANSPARENT));
   // vsync_out is about to fall: the pixel now registered opens a new frame.
   assign vs_fall = vsync_out & ~d_vs;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rgb <= '0;
         hsync_out <= SYNC_IDLE;
         vsync_out <= SYNC_IDLE;
         videoEnable_out <= 1'b0;
         hit_count <= '0;
         counter <= '0;
      end else begin
         hsync_out <= d_hs;
         vsync_out <= d_vs;
         videoEnable_out <= d_ve;
         if (!d_ve) rgb <= '0;
         else if (hit) rgb <= d;
         else rgb <= COLOR_WIDTH'(BACKGROUND);
         if (vs_fall) begin
            hit_count <= counter;
            counter <= 16'(hit);
         end else if (hit && counter != 16'hFFFF) begin
            counter <= counter + 16'd1;
         end
      end
   end
endmodule

// File: tb/tb_sprite_pixel_reader.sv
// Directed bench for sprite_pixel_reader with a scoreboard of
// expected pixels keyed by the cycle they should appear.
module tb_sprite_pixel_reader;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [9:0]  address;
   logic [3:0]  element;
   logic        videoEnable;
   logic        hsync_in;
   logic        vsync_in;
   logic [9:0]  rom_address;
   logic [3:0]  rom_read;
   logic [35:0] rom_data;
   logic [8:0]  rgb;
   logic        hsync_out;
   logic        vsync_out;
   logic        videoEnable_out;
   logic [15:0] hit_count;
   logic        element_error;

   always #5 clk = ~clk;

   sprite_pixel_reader dut (
      .clk(clk),
      .reset(rst_n),
      .enable(enable),
      .address(address),
      .element(element),
      .videoEnable(videoEnable),
      .hsync_in(hsync_in),
      .vsync_in(vsync_in),
      .rom_address(rom_address),
      .rom_read(rom_read),
      .rom_data(rom_data),
      .rgb(rgb),
      .hsync_out(hsync_out),
      .vsync_out(vsync_out),
      .videoEnable_out(videoEnable_out),
      .hit_count(hit_count),
      .element_error(element_error)
   );

   // Four ROMs, two-cycle read latency from rom_address.
   logic [8:0] mem [4][1024];
   logic [8:0] s1 [4];
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         s1[i] <= mem[i][rom_address];
         rom_data[i*9 +: 9] <= s1[i];
      end
   end

   typedef struct {
      int          due;
      logic [8:0]  rgb;
      logic        hs;
      logic        vs;
      logic        ve;
      logic [15:0] hc;
   } exp_t;

   exp_t        q[$];
   int          cyc = 0;
   int          blank_until = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   logic        m_prev_vs = 1'b1;
   logic [15:0] m_cnt = 16'd0;
   logic [15:0] m_hc = 16'd0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_hit(logic en, logic [9:0] a, logic [3:0] el, logic ve);
      if (!ve || !en) return 1'b0;
      for (int i = 0; i < 4; i++)
         if (el[i]) return mem[i][a] != 9'h1FF;
      return 1'b0;
   endfunction

   function automatic logic [8:0] exp_px(logic en, logic [9:0] a, logic [3:0] el, logic ve);
      if (!exp_hit(en, a, el, ve)) return 9'h000;
      for (int i = 0; i < 4; i++)
         if (el[i]) return mem[i][a];
      return 9'h000;
   endfunction

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      if (cyc < blank_until) begin
         chk("blank_rgb", 32'(rgb), 32'h0);
         chk("blank_ve", 32'(videoEnable_out), 32'h0);
      end
      while (q.size() > 0 && q[0].due <= cyc) begin
         e = q.pop_front();
         chk("sb_due", 32'(e.due), 32'(cyc));
         chk("sb_rgb", 32'(rgb), 32'(e.rgb));
         chk("sb_hsync", 32'(hsync_out), 32'(e.hs));
         chk("sb_vsync", 32'(vsync_out), 32'(e.vs));
         chk("sb_ve", 32'(videoEnable_out), 32'(e.ve));
         chk("sb_hits", 32'(hit_count), 32'(e.hc));
      end
   endtask

   task automatic drive(input logic en, input logic [9:0] a, input logic [3:0] el,
                        input logic ve, input logic hs, input logic vs);
      exp_t e;
      logic h;
      enable = en;
      address = a;
      element = el;
      videoEnable = ve;
      hsync_in = hs;
      vsync_in = vs;
      h = exp_hit(en, a, el, ve);
      if (m_prev_vs && !vs) begin
         m_hc = m_cnt;
         m_cnt = h ? 16'd1 : 16'd0;
      end else if (h && m_cnt != 16'hFFFF) begin
         m_cnt = m_cnt + 16'd1;
      end
      m_prev_vs = vs;
      e.due = cyc + 4;
      e.rgb = exp_px(en, a, el, ve);
      e.hs = hs;
      e.vs = vs;
      e.ve = ve;
      e.hc = m_hc;
      q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, 10'd0, 4'd0, 1'b1, 1'b1, 1'b1);
         tick();
      end
   endtask

   task automatic check_reset_vals();
      chk("rst_rom_address", 32'(rom_address), 32'h0);
      chk("rst_rom_read", 32'(rom_read), 32'h0);
      chk("rst_rgb", 32'(rgb), 32'h0);
      chk("rst_hsync", 32'(hsync_out), 32'h1);
      chk("rst_vsync", 32'(vsync_out), 32'h1);
      chk("rst_ve", 32'(videoEnable_out), 32'h0);
      chk("rst_hits", 32'(hit_count), 32'h0);
      chk("rst_err", 32'(element_error), 32'h0);
   endtask

   initial begin
      for (int i = 0; i < 4; i++)
         for (int a = 0; a < 1024; a++)
            mem[i][a] = 9'((i * 97 + a * 13) % 511);
      mem[2][37] = 9'h0A5;
      rst_n = 1'b0;
      enable = 1'b0;
      address = '0;
      element = '0;
      videoEnable = 1'b0;
      hsync_in = 1'b1;
      vsync_in = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals();
      rst_n = 1'b1;
      blank_until = cyc + 4;

      // Opaque ROM2 read
      drive(1'b1, 10'd37, 4'b0100, 1'b1, 1'b1, 1'b1);
      tick();
      chk("rd_strobe", 32'(rom_read), 32'h4);
      chk("rd_addr", 32'(rom_address), 32'd37);
      idle(6);

      // Transparent texel
      mem[2][37] = 9'h1FF;
      drive(1'b1, 10'd37, 4'b0100, 1'b1, 1'b1, 1'b1);
      tick();
      idle(6);

      // Blanked area with an opaque request; sync pattern through
      drive(1'b1, 10'd5, 4'b0001, 1'b0, 1'b0, 1'b1);
      tick();
      drive(1'b1, 10'd6, 4'b1000, 1'b0, 1'b1, 1'b1);
      tick();
      drive(1'b0, 10'd7, 4'b0001, 1'b0, 1'b0, 1'b1);
      tick();
      idle(6);

      // Multi-hot and empty element
      drive(1'b1, 10'd12, 4'b0110, 1'b1, 1'b1, 1'b1);
      tick();
      chk("multi_strobe", 32'(rom_read), 32'h2);
      chk("multi_err", 32'(element_error), 32'h1);
      idle(3);
      chk("err_sticky", 32'(element_error), 32'h1);
      drive(1'b1, 10'd12, 4'b0000, 1'b1, 1'b1, 1'b1);
      tick();
      chk("zero_strobe", 32'(rom_read), 32'h0);
      idle(6);
      chk("err_sticky2", 32'(element_error), 32'h1);

      // Frame with a 25x25 sprite
      drive(1'b0, 10'd0, 4'd0, 1'b0, 1'b1, 1'b0);
      tick();
      drive(1'b0, 10'd0, 4'd0, 1'b0, 1'b1, 1'b0);
      tick();
      for (int i = 0; i < 625; i++) begin
         drive(1'b1, 10'(i), 4'b0001, 1'b1, 1'b1, 1'b1);
         tick();
      end
      idle(10);
      drive(1'b0, 10'd0, 4'd0, 1'b0, 1'b1, 1'b0);
      tick();
      drive(1'b0, 10'd0, 4'd0, 1'b0, 1'b1, 1'b0);
      tick();
      idle(6);
      chk("frame_625", 32'(hit_count), 32'd625);

      // Frame without sprites
      idle(50);
      drive(1'b0, 10'd0, 4'd0, 1'b0, 1'b1, 1'b0);
      tick();
      idle(6);
      chk("frame_0", 32'(hit_count), 32'd0);

      // Reset mid-stream
      mem[3][100] = 9'h123;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 10'd100, 4'b1000, 1'b1, 1'b0, 1'b1);
         tick();
      end
      rst_n = 1'b0;
      #1;
      check_reset_vals();
      q.delete();
      m_prev_vs = 1'b1;
      m_cnt = 16'd0;
      m_hc = 16'd0;
      blank_until = cyc + 100;
      tick();
      rst_n = 1'b1;
      blank_until = cyc + 4;
      drive(1'b1, 10'd100, 4'b1000, 1'b1, 1'b0, 1'b1);
      tick();
      chk("post_rst_err", 32'(element_error), 32'h0);
      idle(6);

      for (int i = 0; i < 20 && q.size() > 0; i++) tick();
      chk("drain_left", 32'(q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
